// File: rtl/issue_hazard_queue.sv
// In-order issue buffer between rename and the functional units. It hands out a
// transaction tag per issued instruction and holds the head while a RAW/WAW
// hazard, or a shortage of tags, is pending.
module issue_hazard_queue #(
    parameter int DEPTH       = 8,
    parameter int PAYLOAD_W   = 64,
    parameter int NR_RF       = 3,
    parameter int NR_WB_PORTS = 4,
    parameter int TAG_W       = 3,
    localparam int RF_W       = (NR_RF > 1) ? $clog2(NR_RF) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         flush_unissued_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [PAYLOAD_W-1:0]         in_payload_i,
    input  logic [4:0]                   in_rd_i,
    input  logic [4:0]                   in_rs1_i,
    input  logic [4:0]                   in_rs2_i,
    input  logic [RF_W-1:0]              in_rd_rf_i,
    input  logic [RF_W-1:0]              in_rs1_rf_i,
    input  logic [RF_W-1:0]              in_rs2_rf_i,
    input  logic                         in_we_i,
    input  logic                         in_use_rs1_i,
    input  logic                         in_use_rs2_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [PAYLOAD_W-1:0]         out_payload_o,
    output logic [TAG_W-1:0]             out_tag_o,
    input  logic [NR_WB_PORTS-1:0]       wb_valid_i,
    input  logic [NR_WB_PORTS*TAG_W-1:0] wb_tag_i,
    output logic [TAG_W:0]               inflight_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int NR_TAGS = 1 << TAG_W;
    localparam int NR_REGS = 32;

    // Both ports transfer on a cycle where valid and ready are high together;
    // valid never depends on ready, and the upstream holds its data while stalled.
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [4:0]           rd_q      [DEPTH];
    logic [4:0]           rs1_q     [DEPTH];
    logic [4:0]           rs2_q     [DEPTH];
    logic [RF_W-1:0]      rd_rf_q   [DEPTH];
    logic [RF_W-1:0]      rs1_rf_q  [DEPTH];
    logic [RF_W-1:0]      rs2_rf_q  [DEPTH];
    logic [DEPTH-1:0]     we_q, use_rs1_q, use_rs2_q;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W:0]     inflight_q, inflight_d, wb_cnt;
    logic [NR_REGS-1:0] busy_q  [NR_RF];
    logic [NR_REGS-1:0] busy_d  [NR_RF];
    logic [TAG_W-1:0]   owner_q [NR_RF][NR_REGS];
    logic [TAG_W-1:0]   owner_d [NR_RF][NR_REGS];
    logic [NR_TAGS-1:0] live_q, live_d;

    logic            empty, full, raw, waw, tag_full, push, issue;
    logic [4:0]      h_rd, h_rs1, h_rs2;
    logic [RF_W-1:0] h_rd_rf, h_rs1_rf, h_rs2_rf;
    logic            h_we, h_use1, h_use2;

    function automatic logic rf_ok(input logic [RF_W-1:0] rf);
        return int'(rf) < NR_RF;
    endfunction

    assign h_rd     = rd_q[rd_ptr_q];
    assign h_rs1    = rs1_q[rd_ptr_q];
    assign h_rs2    = rs2_q[rd_ptr_q];
    assign h_rd_rf  = rd_rf_q[rd_ptr_q];
    assign h_rs1_rf = rs1_rf_q[rd_ptr_q];
    assign h_rs2_rf = rs2_rf_q[rd_ptr_q];
    assign h_we     = we_q[rd_ptr_q];
    assign h_use1   = use_rs1_q[rd_ptr_q];
    assign h_use2   = use_rs2_q[rd_ptr_q];

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign tag_full = (inflight_q == (TAG_W+1)'(NR_TAGS));

    // Hazards look only at registered busy bits: no writeback bypass.
    always_comb begin
        raw = (h_use1 && rf_ok(h_rs1_rf) && busy_q[h_rs1_rf][h_rs1]) ||
              (h_use2 && rf_ok(h_rs2_rf) && busy_q[h_rs2_rf][h_rs2]);
        waw = h_we && rf_ok(h_rd_rf) && busy_q[h_rd_rf][h_rd];
    end

    assign out_valid_o   = !empty && !raw && !waw && !tag_full;
    assign in_ready_o    = !full;
    assign out_payload_o = payload_q[rd_ptr_q];
    assign out_tag_o     = tag_q;
    assign inflight_o    = inflight_q;

    assign push  = in_valid_i && !full && !flush_i && !flush_unissued_i;
    assign issue = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        tag_d      = tag_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        live_d     = live_q;
        wb_cnt     = '0;

        if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !issue) count_d = count_q + (PTR_W+1)'(1);
        if (!push && issue) count_d = count_q - (PTR_W+1)'(1);

        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p]) begin
                wb_cnt = wb_cnt + (TAG_W+1)'(1);
                live_d[wb_tag_i[p*TAG_W +: TAG_W]] = 1'b0;
                for (int f = 0; f < NR_RF; f++) begin
                    for (int r = 0; r < NR_REGS; r++) begin
                        if (owner_q[f][r] == wb_tag_i[p*TAG_W +: TAG_W]) busy_d[f][r] = 1'b0;
                    end
                end
            end
        end
        inflight_d = inflight_q - wb_cnt;

        // Applied after the writeback clears so a same-cycle issue keeps ownership.
        if (issue) begin
            tag_d          = tag_q + TAG_W'(1);
            inflight_d     = inflight_d + (TAG_W+1)'(1);
            live_d[tag_q]  = 1'b1;
            if (h_we && rf_ok(h_rd_rf) && !(h_rd_rf == '0 && h_rd == 5'd0)) begin
                busy_d[h_rd_rf][h_rd]  = 1'b1;
                owner_d[h_rd_rf][h_rd] = tag_q;
            end
        end

        if (flush_unissued_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        if (flush_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            tag_d      = '0;
            inflight_d = '0;
            live_d     = '0;
            busy_d     = '{default: '0};
            owner_d    = '{default: '{default: '0}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            live_q     <= '0;
            busy_q     <= '{default: '0};
            owner_q    <= '{default: '{default: '0}};
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            live_q     <= live_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
        end
    end

    // Entry storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk_i) begin
        if (push) begin
            payload_q[wr_ptr_q] <= in_payload_i;
            rd_q[wr_ptr_q]      <= in_rd_i;
            rs1_q[wr_ptr_q]     <= in_rs1_i;
            rs2_q[wr_ptr_q]     <= in_rs2_i;
            rd_rf_q[wr_ptr_q]   <= in_rd_rf_i;
            rs1_rf_q[wr_ptr_q]  <= in_rs1_rf_i;
            rs2_rf_q[wr_ptr_q]  <= in_rs2_rf_i;
            we_q[wr_ptr_q]      <= in_we_i;
            use_rs1_q[wr_ptr_q] <= in_use_rs1_i;
            use_rs2_q[wr_ptr_q] <= in_use_rs2_i;
        end
    end

    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_chk
        wb_tag_live_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
            wb_valid_i[p] |-> live_q[wb_tag_i[p*TAG_W +: TAG_W]]);
    end

endmodule

// File: tb/tb_issue_hazard_queue.sv
// Directed bench for issue_hazard_queue: independent issue, RAW/WAW stalls,
// stale writeback, full queue with pointer wrap, tag exhaustion, flushes, reset.
module tb_issue_hazard_queue;

    localparam int TAG_W = 3;
    localparam int NWB   = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, flush_unissued_i;
    logic        in_valid_i, in_ready_o;
    logic [63:0] in_payload_i;
    logic [4:0]  in_rd_i, in_rs1_i, in_rs2_i;
    logic [1:0]  in_rd_rf_i, in_rs1_rf_i, in_rs2_rf_i;
    logic        in_we_i, in_use_rs1_i, in_use_rs2_i;
    logic        out_valid_o, out_ready_i;
    logic [63:0] out_payload_o;
    logic [2:0]  out_tag_o;
    logic [NWB-1:0]       wb_valid_i;
    logic [NWB*TAG_W-1:0] wb_tag_i;
    logic [3:0]  inflight_o;

    int n_pass, n_total;

    issue_hazard_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_unissued_i(flush_unissued_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_payload_i(in_payload_i),
        .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_rd_rf_i(in_rd_rf_i), .in_rs1_rf_i(in_rs1_rf_i), .in_rs2_rf_i(in_rs2_rf_i),
        .in_we_i(in_we_i), .in_use_rs1_i(in_use_rs1_i), .in_use_rs2_i(in_use_rs2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_payload_o(out_payload_o),
        .out_tag_o(out_tag_o), .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
        .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic idle_in();
        in_valid_i = 0; in_payload_i = '0; in_we_i = 0;
        in_rd_i = 0; in_rs1_i = 0; in_rs2_i = 0;
        in_rd_rf_i = 0; in_rs1_rf_i = 0; in_rs2_rf_i = 0;
        in_use_rs1_i = 0; in_use_rs2_i = 0;
    endtask

    task automatic push_n(input logic [63:0] pl);
        idle_in();
        in_valid_i = 1; in_payload_i = pl;
    endtask

    task automatic push_w(input logic [63:0] pl, input logic [4:0] rd, input logic [1:0] rf);
        push_n(pl);
        in_we_i = 1; in_rd_i = rd; in_rd_rf_i = rf;
    endtask

    task automatic push_r1(input logic [63:0] pl, input logic [4:0] rs, input logic [1:0] rf);
        push_n(pl);
        in_use_rs1_i = 1; in_rs1_i = rs; in_rs1_rf_i = rf;
    endtask

    task automatic push_r2(input logic [63:0] pl, input logic [4:0] rs, input logic [1:0] rf);
        push_n(pl);
        in_use_rs2_i = 1; in_rs2_i = rs; in_rs2_rf_i = rf;
    endtask

    task automatic set_wb(input int p, input logic [2:0] t);
        wb_valid_i[p] = 1'b1;
        wb_tag_i[p*TAG_W +: TAG_W] = t;
    endtask

    task automatic clr_wb();
        wb_valid_i = '0; wb_tag_i = '0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_ni = 0; flush_i = 0; flush_unissued_i = 0; out_ready_i = 0;
        idle_in(); clr_wb();

        // Reset values, during and after reset
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", in_ready_o, 1);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_tag", out_tag_o, 0);
        chk("rst_inflight", inflight_o, 0);
        rst_ni = 1;
        tick();
        chk("rel_ready", in_ready_o, 1);
        chk("rel_valid", out_valid_o, 0);

        // Three independent writers issue back to back with tags 0,1,2
        out_ready_i = 1;
        push_w(64'hA000, 5, 0); tick();
        chk("ind_v0", out_valid_o, 1);
        chk("ind_tag0", out_tag_o, 0);
        chk("ind_pl0", out_payload_o, 64'hA000);
        push_w(64'hA001, 6, 0); tick();
        chk("ind_tag1", out_tag_o, 1);
        chk("ind_pl1", out_payload_o, 64'hA001);
        chk("ind_inf1", inflight_o, 1);
        push_w(64'hA002, 7, 0); tick();
        chk("ind_tag2", out_tag_o, 2);
        chk("ind_pl2", out_payload_o, 64'hA002);
        idle_in(); tick();
        chk("ind_empty", out_valid_o, 0);
        chk("ind_inf3", inflight_o, 3);
        set_wb(0, 0); set_wb(1, 1); set_wb(2, 2); tick(); clr_wb();
        chk("ind_retired", inflight_o, 0);

        // RAW: B reads x5 written by A (tag 3)
        push_w(64'hB000, 5, 0); tick();
        chk("raw_a_tag", out_tag_o, 3);
        push_r1(64'hB001, 5, 0); tick(); idle_in();
        chk("raw_hold0", out_valid_o, 0);
        chk("raw_inf", inflight_o, 1);
        tick();
        chk("raw_hold1", out_valid_o, 0);
        set_wb(2, 3); #1;
        chk("raw_nobypass", out_valid_o, 0);
        tick(); clr_wb();
        chk("raw_go", out_valid_o, 1);
        chk("raw_b_tag", out_tag_o, 4);
        chk("raw_b_pl", out_payload_o, 64'hB001);
        tick();
        chk("raw_b_issued", out_valid_o, 0);
        chk("raw_b_inf", inflight_o, 1);
        set_wb(0, 4); tick(); clr_wb();
        chk("raw_retired", inflight_o, 0);

        // Fill the queue (pointers start at 5, so they wrap), then drain
        out_ready_i = 0;
        for (int i = 0; i < 8; i++) begin
            push_n(64'hC00 + 64'(i)); tick();
            if (i == 6) chk("full_not_yet", in_ready_o, 1);
        end
        chk("full_ready", in_ready_o, 0);
        push_n(64'hCFF); tick();
        chk("full_head_pl", out_payload_o, 64'hC00);
        chk("full_head_tag", out_tag_o, 5);
        out_ready_i = 1; tick();
        idle_in();
        chk("full_pushpop_ready", in_ready_o, 1);
        for (int i = 1; i < 8; i++) begin
            logic [2:0] et;
            et = 3'(5 + i);
            chk("drain_pl", out_payload_o, 64'hC00 + 64'(i));
            chk("drain_tag", out_tag_o, 64'(et));
            tick();
        end
        chk("tf_valid", out_valid_o, 0);
        chk("tf_inf8", inflight_o, 8);

        // Tags exhausted: next instruction waits for one writeback
        push_n(64'hCAA); tick(); idle_in();
        chk("tf_hold", out_valid_o, 0);
        chk("tf_hold_inf", inflight_o, 8);
        set_wb(0, 5); tick(); clr_wb();
        chk("tf_go", out_valid_o, 1);
        chk("tf_tag", out_tag_o, 5);
        chk("tf_pl", out_payload_o, 64'hCAA);
        tick();
        chk("tf_inf_again", inflight_o, 8);
        set_wb(0, 6); set_wb(1, 7); set_wb(2, 0); set_wb(3, 1); tick();
        chk("tf_inf4", inflight_o, 4);
        set_wb(0, 2); set_wb(1, 3); set_wb(2, 4); set_wb(3, 5); tick(); clr_wb();
        chk("tf_inf0", inflight_o, 0);

        // Full flush with a same-cycle push that must be dropped
        flush_i = 1; push_n(64'hDEAD); tick(); flush_i = 0; idle_in();
        chk("fl_valid", out_valid_o, 0);
        chk("fl_tag", out_tag_o, 0);
        chk("fl_ready", in_ready_o, 1);

        // WAW on x3 of rf 1, then a writeback of a non-owner tag
        push_w(64'hE000, 3, 1); tick();
        chk("waw_a_tag", out_tag_o, 0);
        push_w(64'hE001, 3, 1); tick(); idle_in();
        chk("waw_hold", out_valid_o, 0);
        chk("waw_inf", inflight_o, 1);
        tick();
        chk("waw_hold2", out_valid_o, 0);
        set_wb(1, 0); tick(); clr_wb();
        chk("waw_go", out_valid_o, 1);
        chk("waw_b_tag", out_tag_o, 1);
        chk("waw_b_pl", out_payload_o, 64'hE001);
        tick();
        push_n(64'hE002); tick(); idle_in();
        chk("waw_c_tag", out_tag_o, 2);
        tick();
        push_r2(64'hE003, 3, 1); set_wb(3, 2); tick(); idle_in(); clr_wb();
        chk("stale_hold", out_valid_o, 0);
        chk("stale_inf", inflight_o, 1);
        set_wb(0, 1); tick(); clr_wb();
        chk("stale_go", out_valid_o, 1);
        chk("stale_tag", out_tag_o, 3);
        chk("stale_pl", out_payload_o, 64'hE003);
        tick();
        chk("stale_inf1", inflight_o, 1);
        flush_i = 1; tick(); flush_i = 0;
        chk("fl1_inf", inflight_o, 0);

        // flush_unissued keeps in-flight state and busy bits
        push_w(64'hF000, 8, 2); tick();
        push_w(64'hF001, 9, 0); tick();
        push_n(64'hF002); tick();
        out_ready_i = 0;
        push_n(64'hF003); tick();
        push_n(64'hF004); tick();
        push_n(64'hF005); tick(); idle_in();
        chk("fu_pre_valid", out_valid_o, 1);
        chk("fu_pre_pl", out_payload_o, 64'hF002);
        chk("fu_pre_inf", inflight_o, 2);
        flush_unissued_i = 1; push_n(64'hF0FF); tick(); flush_unissued_i = 0; idle_in();
        chk("fu_empty", out_valid_o, 0);
        chk("fu_inf", inflight_o, 2);
        chk("fu_tag", out_tag_o, 2);
        out_ready_i = 1;
        push_r1(64'hF006, 8, 2); tick(); idle_in();
        chk("fu_busy_kept", out_valid_o, 0);
        flush_i = 1; tick(); flush_i = 0;
        chk("fl2_inf", inflight_o, 0);
        chk("fl2_valid", out_valid_o, 0);
        push_r1(64'hF007, 8, 2); tick(); idle_in();
        chk("fl2_go", out_valid_o, 1);
        chk("fl2_tag", out_tag_o, 0);
        chk("fl2_pl", out_payload_o, 64'hF007);

        // Asynchronous reset in the middle of traffic
        tick();
        push_n(64'h1234); tick(); idle_in();
        chk("pre_rst_inf", inflight_o, 1);
        rst_ni = 0; #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_tag", out_tag_o, 0);
        chk("arst_inf", inflight_o, 0);
        chk("arst_ready", in_ready_o, 1);
        tick();
        rst_ni = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
